// File: rtl/dotprod_loader.sv
// dotprod_loader -- operand loader and memory server for dotprod.
//
// Accepts a stream of (a, b) pairs into two single-port arrays, latches the
// element count on n, then holds ap_start until dotprod signals ap_done.
// The a_*/b_* read ports are served with one cycle of latency in every state.
//
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   in_valid/in_ready       pair handshake; in_a, in_b data, in_last ends vector
//   a_address0/a_ce0/a_q0   array A read port (address in, enable in, data out)
//   b_address0/b_ce0/b_q0   array B read port
//   n                       element count of the loaded vector
//   ap_start/ap_done        start to / completion from dotprod
//   busy                    vector loaded and dotprod running
//   ovf                     sticky: a vector exceeded DEPTH
//
// Build option:
//   DOTPROD_LOADER_BOUNDS_CHECK_EN  when defined, reads at address >= n or with
//                                   any of bits [31:AW] set return 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_LOAD    | accepting pairs and writing them at wr_ptr
// S_DISCARD | vector overflowed DEPTH; dropping beats until in_last
// S_RUN     | vector loaded, ap_start high, waiting for ap_done
module dotprod_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  input  logic [31:0]   a_address0,
  input  logic          a_ce0,
  output logic [DW-1:0] a_q0,
  input  logic [31:0]   b_address0,
  input  logic          b_ce0,
  output logic [DW-1:0] b_q0,
  output logic [31:0]   n,
  output logic          ap_start,
  input  logic          ap_done,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {S_LOAD, S_DISCARD, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]   n_q, n_d;
  logic          ap_start_q, ap_start_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] a_q_q, a_q_d;
  logic [DW-1:0] b_q_q, b_q_d;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  logic accept;
  logic wr_en;
  logic a_ok, b_ok;

  assign in_ready = ((state_q == S_LOAD) || (state_q == S_DISCARD)) & ~ap_rst;
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept & (state_q == S_LOAD);

`ifdef DOTPROD_LOADER_BOUNDS_CHECK_EN
  // n never exceeds DEPTH, but the upper-bit test is kept explicit so the
  // rule stays obvious if the count ever grows wider than the index.
  assign a_ok = (a_address0[31:AW] == '0) && (a_address0 < n_q);
  assign b_ok = (b_address0[31:AW] == '0) && (b_address0 < n_q);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{a_address0[31:AW], b_address0[31:AW]};
  assign a_ok = 1'b1;
  assign b_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    n_d        = n_q;
    ap_start_d = ap_start_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last) begin
            n_d        = 32'(wr_ptr_q) + 32'd1;
            state_d    = S_RUN;
            ap_start_d = 1'b1;
            busy_d     = 1'b1;
          end else if (wr_ptr_q == (AW+1)'(DEPTH-1)) begin
            n_d     = 32'(DEPTH);
            ovf_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (accept && in_last) begin
          state_d    = S_RUN;
          ap_start_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        if (ap_done) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          ap_start_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Read data is computed from the arrays before this edge's write lands,
  // so a same-address collision returns the old contents.
  always_comb begin
    a_q_d = a_q_q;
    b_q_d = b_q_q;
    if (a_ce0) a_q_d = a_ok ? mem_a[a_address0[AW-1:0]] : '0;
    if (b_ce0) b_q_d = b_ok ? mem_b[b_address0[AW-1:0]] : '0;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= S_LOAD;
      wr_ptr_q   <= '0;
      n_q        <= '0;
      ap_start_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      a_q_q      <= '0;
      b_q_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      n_q        <= n_d;
      ap_start_q <= ap_start_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      a_q_q      <= a_q_d;
      b_q_q      <= b_q_d;
    end
  end

  // Array storage is deliberately not reset.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem_a[wr_ptr_q[AW-1:0]] <= in_a;
      mem_b[wr_ptr_q[AW-1:0]] <= in_b;
    end
  end

  assign a_q0     = a_q_q;
  assign b_q0     = b_q_q;
  assign n        = n_q;
  assign ap_start = ap_start_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_dotprod_loader.sv
// tb_dotprod_loader -- directed plus randomized bench for dotprod_loader.
// The reference keeps plain arrays of what each operand array should hold,
// fed from the list of accepted beats of each vector.
module tb_dotprod_loader;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_last = 1'b0;
  logic [31:0]   a_address0 = '0;
  logic          a_ce0 = 1'b0;
  logic [DW-1:0] a_q0;
  logic [31:0]   b_address0 = '0;
  logic          b_ce0 = 1'b0;
  logic [DW-1:0] b_q0;
  logic [31:0]   n;
  logic          ap_start;
  logic          ap_done = 1'b0;
  logic          busy;
  logic          ovf;

  dotprod_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .a_address0(a_address0), .a_ce0(a_ce0), .a_q0(a_q0),
    .b_address0(b_address0), .b_ce0(b_ce0), .b_q0(b_q0),
    .n(n), .ap_start(ap_start), .ap_done(ap_done), .busy(busy), .ovf(ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference contents and status
  logic [DW-1:0] ref_a [DEPTH];
  logic [DW-1:0] ref_b [DEPTH];
  int            vcount = 0;
  int            model_n = 0;
  bit            model_ovf = 1'b0;

  // beats the next send() offers
  logic [DW-1:0] da [128];
  logic [DW-1:0] db [128];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [31:0] ad, input bit is_b);
`ifdef DOTPROD_LOADER_BOUNDS_CHECK_EN
    if (ad >= 32'(model_n)) return '0;
`endif
    return is_b ? ref_b[ad[AW-1:0]] : ref_a[ad[AW-1:0]];
  endfunction

  // Offers nb beats; with rnd_valid, in_valid toggles randomly and idle
  // cycles carry garbage data that must never land in the arrays.
  task automatic send(input int nb, input bit last_at_end, input bit rnd_valid);
    int i = 0;
    int cyc = 0;
    while (i < nb && cyc < 2000) begin
      in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a     = in_valid ? da[i] : $urandom;
      in_b     = in_valid ? db[i] : $urandom;
      in_last  = last_at_end && (i == nb - 1);
      chk("in_ready_load", in_ready, 1);
      @(posedge ap_clk);
      if (in_valid) begin
        if (vcount < DEPTH) begin
          ref_a[vcount] = da[i];
          ref_b[vcount] = db[i];
        end
        vcount++;
        i++;
      end
      #1;
      cyc++;
    end
    if (cyc >= 2000) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last_at_end) begin
      model_n = (vcount > DEPTH) ? DEPTH : vcount;
      if (vcount > DEPTH) model_ovf = 1'b1;
    end
  endtask

  task automatic check_loaded();
    chk("ap_start_run", ap_start, 1);
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    chk("n", n, 64'(model_n));
    chk("ovf", ovf, 64'(model_ovf));
  endtask

  task automatic rd(input logic [31:0] aa, input logic [31:0] ba);
    logic [DW-1:0] ea, eb;
    ea = exp_rd(aa, 1'b0);
    eb = exp_rd(ba, 1'b1);
    a_address0 = aa; b_address0 = ba;
    a_ce0 = 1'b1; b_ce0 = 1'b1;
    @(posedge ap_clk); #1;
    chk("a_q0", a_q0, 64'(ea));
    chk("b_q0", b_q0, 64'(eb));
    a_ce0 = 1'b0; b_ce0 = 1'b0;
    a_address0 = $urandom; b_address0 = $urandom;
    @(posedge ap_clk); #1;
    chk("a_q0_hold", a_q0, 64'(ea));
    chk("b_q0_hold", b_q0, 64'(eb));
  endtask

  task automatic finish_run();
    ap_done = 1'b1;
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    ap_done = 1'b0;
    chk("ap_start_done", ap_start, 0);
    chk("busy_done", busy, 0);
    chk("in_ready_done", in_ready, 1);
    vcount = 0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_a_q0", a_q0, 0);
    chk("rst_b_q0", b_q0, 0);
    chk("rst_n", n, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // directed 4-pair vector
    for (int i = 0; i < 4; i++) begin
      da[i] = DW'(i + 1);
      db[i] = DW'(i + 5);
    end
    send(4, 1'b1, 1'b0);
    check_loaded();
    rd(32'd2, 32'd2);
    chk("a_q0_addr2_is_3", a_q0, 3);
    chk("b_q0_addr2_is_7", b_q0, 7);

    // in_valid held during RUN must not be accepted or written
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a = $urandom; in_b = $urandom; in_last = 1'($urandom_range(0, 1));
      @(posedge ap_clk); #1;
      chk("in_ready_run_hold", in_ready, 0);
      chk("ap_start_run_hold", ap_start, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) rd(32'(i), 32'(3 - i));
    finish_run();

    // 2-pair vector
    for (int i = 0; i < 2; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    send(2, 1'b1, 1'b0);
    check_loaded();
    rd(32'd0, 32'd1);
    rd(32'd1, 32'd0);
    finish_run();

    // ap_done outside RUN has no effect
    ap_done = 1'b1;
    @(posedge ap_clk); #1;
    ap_done = 1'b0;
    chk("done_idle_in_ready", in_ready, 1);
    chk("done_idle_ap_start", ap_start, 0);
    chk("done_idle_n", n, 2);

    // 70-pair overflow vector
    for (int i = 0; i < 70; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    send(70, 1'b1, 1'b0);
    check_loaded();
    for (int i = 0; i < DEPTH; i++) rd(32'(i), 32'(DEPTH - 1 - i));
    finish_run();

    // address boundaries on a short vector over old contents
    for (int i = 0; i < 4; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    send(4, 1'b1, 1'b0);
    check_loaded();
    rd(32'd5, 32'd5);
    rd(32'h40, 32'h43);
    rd(32'h8000_0001, 32'd3);
    finish_run();

    // randomly gapped 10-beat vector
    for (int i = 0; i < 10; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    send(10, 1'b1, 1'b1);
    check_loaded();
    chk("n_is_10", n, 10);
    for (int i = 0; i < 10; i++) rd(32'(i), 32'(9 - i));
    finish_run();

    // reset in the middle of a 5-beat vector
    for (int i = 0; i < 5; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    a_address0 = 32'd1; a_ce0 = 1'b1; b_address0 = 32'd1; b_ce0 = 1'b1;
    send(3, 1'b0, 1'b0);
    a_ce0 = 1'b0; b_ce0 = 1'b0;
    #1;
    ap_rst = 1'b1;
    #1;
    vcount = 0; model_n = 0; model_ovf = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_a_q0", a_q0, 0);
    chk("mid_rst_b_q0", b_q0, 0);
    chk("mid_rst_n", n, 0);
    chk("mid_rst_ap_start", ap_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 2; i++) begin
      da[i] = $urandom; db[i] = $urandom;
    end
    send(2, 1'b1, 1'b0);
    check_loaded();
    rd(32'd0, 32'd1);
    rd(32'd1, 32'd0);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dotprod_loader.md
# dotprod_loader

Upstream operand stage for `dotprod`. It accepts a stream of (a, b) element pairs, writes them into two internal single-port arrays, and latches the element count onto `n`. It then raises `ap_start` and keeps it high until `dotprod` reports `ap_done`. While `dotprod` runs, the block serves its `a_*`/`b_*` memory read ports with one-cycle latency.

## Interface
Parameters:
- `DEPTH`, 64: entries per operand array; power of two.
- `AW`, 6: log2(DEPTH); address bits used for indexing.
- `DW`, 32: element width.

Ports:
- `ap_clk` in 1: the single clock.
- `ap_rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: producer has a pair.
- `in_ready` out 1: block accepts a pair.
- `in_a` in DW: a element.
- `in_b` in DW: b element.
- `in_last` in 1: final pair of the vector.
- `a_address0` in 32: read address from `dotprod`.
- `a_ce0` in 1: read enable from `dotprod`.
- `a_q0` out DW: read data to `dotprod`.
- `b_address0`, `b_ce0`, `b_q0`: same as the `a_*` ports, for array b.
- `n` out 32: element count of the loaded vector.
- `ap_start` out 1: start to `dotprod`.
- `ap_done` in 1: completion from `dotprod`.
- `busy` out 1: a vector is loaded and `dotprod` is running.
- `ovf` out 1: sticky; a vector exceeded DEPTH.

## Operation
- State machine: LOAD, DISCARD, RUN. Reset state is LOAD.
- A beat is accepted when `in_valid & in_ready`.
- `in_ready` = (state==LOAD or DISCARD) & ~`ap_rst`.
- LOAD:
  - An accepted beat writes `in_a`→A[wr_ptr] and `in_b`→B[wr_ptr], then increments wr_ptr.
  - Accepted beat with `in_last`: `n` ← wr_ptr+1, next state RUN.
  - Accepted beat at wr_ptr==DEPTH-1 without `in_last`: `n` ← DEPTH, `ovf` ← 1, next state DISCARD.
- DISCARD: accepted beats are dropped. An accepted beat with `in_last` moves to RUN.
- RUN:
  - `ap_start`=1, `busy`=1, `in_ready`=0.
  - `ap_done`=1 → next state LOAD, wr_ptr ← 0, `ap_start` and `busy` fall on the same edge.
- `ap_done` is ignored outside RUN.
- `n` holds its value until the next vector completes loading.
- Reads:
  - When `a_ce0`=1, `a_q0` ← A[`a_address0`[AW-1:0]] on the next edge.
  - When `a_ce0`=0, `a_q0` holds its value. B is identical and independent.
  - Reads are serviced in every state.
- Write/read collision on the same address in LOAD returns the old data. `dotprod` does not read during LOAD.
- Counter widths: wr_ptr is AW+1 bits internally. `n` is zero-extended to 32 bits.
- `ovf` is cleared only by reset.

## Timing
- Reset values: `in_ready`=0 while `ap_rst` is high, then 1. `a_q0`=0, `b_q0`=0, `n`=0, `ap_start`=0, `busy`=0, `ovf`=0. Array contents are not cleared.
- Write takes effect on the accepting edge. Data is readable from the next cycle.
- `ap_start` rises in the cycle after the `in_last` beat is accepted. This is one cycle after the last write, so the arrays are stable before `dotprod` first reads.
- Read latency is exactly 1 cycle from the `ce` edge.
- Minimum turnaround: `ap_done` at edge k → `in_ready`=1 in cycle k+1.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronous). State → LOAD, wr_ptr → 0, and any in-flight vector is lost.
- Throughput: one pair per cycle in LOAD and DISCARD.

## Configuration
- `DOTPROD_LOADER_BOUNDS_CHECK_EN`:
  - Defined: a read whose `*_address0` is ≥ `n`, or whose bits [31:AW] are nonzero, returns 0.
  - Undefined: the address is truncated to [AW-1:0] and raw array contents are returned, with no comparison logic.

## Test plan
- Load 4 pairs (a=1,2,3,4; b=5,6,7,8), `in_last` on the 4th → `n`=4; `ap_start`=1 the next cycle; a read at addr 2 with `ce` returns `a_q0`=3, `b_q0`=7 one cycle later.
- Hold `in_valid` during RUN, then pulse `ap_done` → no writes occur during RUN; `ap_start`, `busy`→0 and `in_ready`→1 on the next cycle; a new 2-pair vector gives `n`=2.
- Send 70 pairs with DEPTH=64, `in_last` on the 70th → `ovf`=1, `n`=64; beats 65–70 are dropped; A[0..63] hold beats 1–64.
- Assert `ap_rst` after 3 of 5 beats → all outputs return to reset values; after release, a 2-pair vector loads with `n`=2.
- With the bounds-check macro defined, `n`=4: a read at addr 5 → 0; a read at 0x40 → 0. Without the macro: a read at addr 5 returns A[5]; a read at 0x40 returns A[0].
- Toggle `in_valid` randomly across a 10-beat load → only accepted beats are written, in order, and `n`=10.
